// File: rtl/bp_resolve_unit.sv
// ============================================================================
// Module   : bp_resolve_unit
// Purpose  : BTB update side. It keeps in-order fetch predictions, resolves them
//            oldest-first, raises flush/redirect on mispredict and writes the BTB.
// Options  : BP_STATS_EN enables the resolved-branch and mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pred_valid,
  output logic               pred_ready,
  input  logic [31:0]        pred_pc,
  input  logic               pred_hit,
  input  logic [1:0]         pred_state,
  input  logic [31:0]        pred_target,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic               res_taken,
  input  logic [31:0]        res_target,
  output logic               flush,
  output logic [31:0]        redirect_pc,
  output logic               upd_valid,
  output logic [IDX_W-1:0]   upd_index,
  output logic [29-IDX_W:0]  upd_tag,
  output logic [1:0]         upd_state,
  output logic [31:0]        upd_target,
  output logic [31:0]        stat_branches,
  output logic [31:0]        stat_mispredicts
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [31:0]      r_pc_q     [DEPTH];
  logic             r_hit_q    [DEPTH];
  logic [1:0]       r_state_q  [DEPTH];
  logic [31:0]      r_target_q [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_pred_ready;
  logic             w_res_ready;
  logic             w_pop;
  logic             w_push;
  logic             w_mispredict;
  logic [31:0]      w_head_pc;
  logic             w_head_hit;
  logic [1:0]       w_head_state;
  logic [31:0]      w_head_target;
  logic [31:0]      w_seq_pc;
  logic [31:0]      w_pred_next;
  logic [31:0]      w_actual_next;
  logic [1:0]       w_new_state;

  logic             r_flush;
  logic [31:0]      r_redirect_pc;
  logic             r_upd_valid;
  logic [IDX_W-1:0] r_upd_index;
  logic [29-IDX_W:0] r_upd_tag;
  logic [1:0]       r_upd_state;
  logic [31:0]      r_upd_target;

  // Ready signals depend on occupancy only, never on the valid inputs.
  assign w_pred_ready = (r_count != C_FULL);
  assign w_res_ready  = (r_count != '0);

  assign w_head_pc     = r_pc_q[r_rd_ptr];
  assign w_head_hit    = r_hit_q[r_rd_ptr];
  assign w_head_state  = r_state_q[r_rd_ptr];
  assign w_head_target = r_target_q[r_rd_ptr];

  assign w_seq_pc      = w_head_pc + 32'd4;
  assign w_pred_next   = (w_head_hit & w_head_state[1]) ? w_head_target : w_seq_pc;
  assign w_actual_next = res_taken ? res_target : w_seq_pc;

  assign w_pop        = res_valid & w_res_ready;
  assign w_mispredict = w_pop & (w_pred_next != w_actual_next);
  // A push racing a mispredict belongs to the wrong path and is dropped.
  assign w_push       = pred_valid & w_pred_ready & ~w_mispredict;

  always_comb begin
    w_new_state = 2'b10;
    if (w_head_hit) begin
      if (res_taken) begin
        w_new_state = (w_head_state == 2'b11) ? 2'b11 : w_head_state + 2'b01;
      end else begin
        w_new_state = (w_head_state == 2'b00) ? 2'b00 : w_head_state - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]     <= pred_pc;
      r_hit_q[r_wr_ptr]    <= pred_hit;
      r_state_q[r_wr_ptr]  <= pred_state;
      r_target_q[r_wr_ptr] <= pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_mispredict) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_upd_valid   <= 1'b0;
      r_upd_index   <= '0;
      r_upd_tag     <= '0;
      r_upd_state   <= '0;
      r_upd_target  <= '0;
    end else begin
      r_flush     <= w_mispredict;
      r_upd_valid <= w_pop & (w_head_hit | res_taken);
      if (w_mispredict) r_redirect_pc <= w_actual_next;
      if (w_pop) begin
        r_upd_index  <= w_head_pc[IDX_W+1:2];
        r_upd_tag    <= w_head_pc[31:IDX_W+2];
        r_upd_state  <= w_new_state;
        r_upd_target <= res_taken ? res_target : w_head_target;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_pop)        r_stat_branches    <= r_stat_branches + 32'd1;
      if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

  assign pred_ready  = w_pred_ready;
  assign res_ready   = w_res_ready;
  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;
  assign upd_valid   = r_upd_valid;
  assign upd_index   = r_upd_index;
  assign upd_tag     = r_upd_tag;
  assign upd_state   = r_upd_state;
  assign upd_target  = r_upd_target;

endmodule

`default_nettype wire
